imem_loader: RTL and testbench
==============================

# imem_loader

Write-side companion to the instruction fetch path: accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian instruction words, and writes them sequentially into the instruction RAM write port. The block holds the CPU (PC, fetch) stopped via `cpu_run` until a complete image has been written. It sits between a byte source (UART receiver, debug bridge or testbench) and port A of the instruction memory. Fetch resumes only after `done`.

## Interface
- `ADDR_W`, 10, instruction RAM word-address width; capacity is 2^ADDR_W words.
- `clk` in 1: system clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; in DONE or ERROR it begins a reload.
- `in_valid` in 1: source has a byte on `in_data`.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle; a byte transfers when `in_valid && in_ready`.
- `mem_we` out 1: instruction RAM write enable, one-cycle pulse per word.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: instruction word.
- `cpu_run` out 1: high releases the PC/fetch; low holds the CPU.
- `done` out 1: image complete; level output.
- `error` out 1: load aborted; level output.
- `words_loaded` out ADDR_W+1: number of words written in the current load.

## Operation
- Stream format: 2-byte word count N (MSB first), then 4·N data bytes; each word is MSB first.
- FSM states: HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR, plus CHECK when the checksum feature is enabled.
- Reset: state HDR_HI. All outputs are 0 except `in_ready`, which is 1. This includes `mem_addr`, `mem_wdata`, `words_loaded`, `cpu_run`, `done` and `error`.
- HDR_HI: on transfer, latch N[15:8] and go to HDR_LO.
- HDR_LO: on transfer, latch N[7:0]. Next state:
  - N==0: DONE.
  - N>2^ADDR_W: ERROR.
  - Otherwise: DATA.
- DATA: shift each byte into the word (`w <= {w[23:0], byte}`) and increment a 2-bit byte counter. On the 4th byte, go to WRITE.
- WRITE (one cycle):
  - `mem_we`=1, `mem_wdata`=packed word, `mem_addr`=current word address.
  - `in_ready`=0.
  - Word address and `words_loaded` increment.
  - Next state: DATA if `words_loaded`+1 < N; otherwise DONE (or CHECK when the checksum feature is enabled).
- DONE: `done`=1, `cpu_run`=1, `in_ready`=0. On `start`: clear counters and `done`, drop `cpu_run` in the same edge, go to HDR_HI.
- ERROR: `error`=1, `cpu_run`=0, `in_ready`=0. `start` behaves as in DONE, and also clears `error`.
- `start` is ignored in all other states.
- Word addresses start at 0 for every load. N==2^ADDR_W writes the last address 2^ADDR_W−1; no wrap-around occurs.
- Reset during any state discards any partial word and header. No write is issued in the reset cycle.

## Timing
- `in_ready` is a registered function of state and does not depend combinationally on `in_valid`.
- One byte per cycle is sustainable in HDR_HI, HDR_LO and DATA. A 4-byte word therefore costs at least 5 cycles.
- `mem_we` asserts in the cycle after the 4th byte's transfer edge. Address and data are stable in that same cycle.
- `done` and `cpu_run` rise in the cycle after the final WRITE cycle, or after the HDR_LO transfer when N==0.
- Source stalls (`in_valid`=0) hold state with no side effects.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last word, CHECK accepts one extra byte.
  - The byte is compared against the XOR of all 4·N data bytes (header excluded).
  - Match → DONE; mismatch → ERROR. Words already written stay in RAM.
  - N==0 also passes through CHECK, with an expected value of 0x00.
- Not defined: CHECK state, XOR accumulator and compare logic are absent. The last WRITE goes directly to DONE.

## Structure
- Shared package `imem_loader_pkg` holds:
  - the state enum;
  - the default `ADDR_W`;
  - `HDR_BYTES`=2 and `BYTES_PER_WORD`=4 constants.
- One natural sub-module, `byte_packer`: byte shift register, 2-bit byte counter, `word_valid` strobe, and synchronous clear. The FSM, address counter and checksum stay in `imem_loader`.

## Test plan
- Load N=2 with bytes 00 02 20 08 00 05 20 09 00 07 → writes 0x20080005@0 then 0x20090007@1. `done`/`cpu_run` rise one cycle after the second `mem_we`; `words_loaded`=2.
- Same image with `in_valid` toggled every other cycle → identical writes, and no `mem_we` while stalled.
- Header 04 01 with ADDR_W=10 (N=1025) → ERROR, no writes, `cpu_run`=0. Then `start` plus header 00 00 → DONE.
- `rst` asserted after 3 data bytes, then a fresh N=1 image → a single write @0 with the new word only.
- With `IMEM_LOADER_CHECKSUM_EN` defined: N=1 with word 01 02 03 04 and checksum 04 → DONE; the same image with checksum 05 → ERROR.
- In DONE, `start` pulse → `cpu_run` falls the next cycle, `in_ready`=1, and the reload of N=1 writes to address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum state.
package imem_loader_pkg;

  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_ERROR  = 3'd5,
    S_CHECK  = 3'd6
`else
    S_ERROR  = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into 32-bit big-endian words; word_valid flags the
// byte that completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= {r_word[23:0], i_byte};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = i_shift && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction image loader: header N, then 4*N big-endian bytes.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_t        r_state, w_next;
  logic [15:0]   r_n;
  logic [15:0]   w_n;
  logic [ADDR_W:0] r_words;
  logic          w_xfer, w_clr, w_shift, w_word_valid;
  logic [31:0]   w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    r_xor;
`endif

  assign w_xfer  = in_valid && in_ready;
  assign w_clr   = start && (r_state == S_DONE || r_state == S_ERROR);
  assign w_shift = w_xfer && (r_state == S_DATA);
  assign w_n     = {r_n[15:8], in_data};

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_shift      (w_shift),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR_HI;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR_HI: if (w_xfer) w_next = S_HDR_LO;
      S_HDR_LO: if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (w_n == 16'd0)                          w_next = S_CHECK;
`else
        if (w_n == 16'd0)                          w_next = S_DONE;
`endif
        else if (32'(w_n) > (32'd1 << ADDR_W))     w_next = S_ERROR;
        else                                       w_next = S_DATA;
      end
      S_DATA:   if (w_word_valid) w_next = S_WRITE;
      S_WRITE: begin
        if (32'(r_words) + 32'd1 < 32'(r_n)) w_next = S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else                                 w_next = S_CHECK;
`else
        else                                 w_next = S_DONE;
`endif
      end
      S_DONE, S_ERROR: if (start) w_next = S_HDR_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: if (w_xfer) w_next = (in_data == r_xor) ? S_DONE : S_ERROR;
`endif
      default:  w_next = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_n     <= '0;
      r_words <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor   <= '0;
`endif
    end else begin
      if (w_xfer && r_state == S_HDR_HI) r_n[15:8] <= in_data;
      if (w_xfer && r_state == S_HDR_LO) r_n[7:0]  <= in_data;
      if (r_state == S_WRITE)            r_words   <= r_words + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_shift)                       r_xor     <= r_xor ^ in_data;
`endif
    end
  end

  // Outputs decode the registered state only, never in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_HDR_HI, S_HDR_LO, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:                    in_ready = 1'b1;
`endif
      default:                    in_ready = 1'b0;
    endcase
  end

  assign mem_we       = (r_state == S_WRITE);
  assign mem_addr     = r_words[ADDR_W-1:0];
  assign mem_wdata    = w_word;
  assign done         = (r_state == S_DONE);
  assign cpu_run      = (r_state == S_DONE);
  assign error        = (r_state == S_ERROR);
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued by the
// stimulus and consumed by a monitor that watches mem_we.
module tb_imem_loader;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, mem_we, cpu_run, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%h@%0d expected=none", mem_wdata, mem_addr);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write actual=%h@%0d expected=%h@%0d",
                   mem_wdata, mem_addr, e[31:0], e[AW+31:32]);
        end
      end
    end
  end

  task automatic expect_write(input int unsigned addr, input logic [31:0] data);
    exp_q.push_back({AW'(addr), data});
  endtask

  // Drive one byte; returns #1 after its transfer edge.
  task automatic send(input logic [7:0] b, input bit stall);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (stall) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_test1(input bit stall);
    send(8'h00, stall); send(8'h02, stall);
    send(8'h20, stall); send(8'h08, stall); send(8'h00, stall); send(8'h05, stall);
    send(8'h20, stall); send(8'h09, stall); send(8'h00, stall); send(8'h07, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", {mem_we, cpu_run, done, error}, 32'd0);
    chk("rst_addr_data", {mem_addr, mem_wdata[21:0]}, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    // Two-word image, back to back.
    expect_write(0, 32'h20080005);
    expect_write(1, 32'h20090007);
    send_test1(1'b0);
    chk("t1_we_latency", {mem_we, done, in_ready}, 32'b100);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(posedge clk); #1;
    send(8'h03, 1'b0);
`else
    @(posedge clk); #1;
`endif
    chk("t1_done", {done, cpu_run, mem_we, in_ready, error}, 32'b11000);
    chk("t1_words", 32'(words_loaded), 32'd2);

    pulse_start();
    chk("restart_run_low", {cpu_run, done, in_ready}, 32'b001);
    chk("restart_words", 32'(words_loaded), 32'd0);

    // Same image with in_valid toggled.
    expect_write(0, 32'h20080005);
    expect_write(1, 32'h20090007);
    send_test1(1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(posedge clk); #1;
    send(8'h03, 1'b0);
`else
    repeat (2) @(posedge clk); #1;
`endif
    chk("t2_done", {done, cpu_run}, 32'b11);
    chk("t2_words", 32'(words_loaded), 32'd2);

    // Oversized header -> ERROR, then empty image.
    pulse_start();
    send(8'h04, 1'b0); send(8'h01, 1'b0);
    chk("t3_error", {error, cpu_run, done, in_ready}, 32'b1000);
    pulse_start();
    chk("t3_error_clr", {error, in_ready}, 32'b01);
    send(8'h00, 1'b0); send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 1'b0);
`endif
    chk("t3_empty_done", {done, cpu_run, error}, 32'b110);
    chk("t3_words", 32'(words_loaded), 32'd0);

    // Reset after three data bytes, then a fresh one-word image.
    pulse_start();
    send(8'h00, 1'b0); send(8'h01, 1'b0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_rst_state", {in_ready, mem_we, done, error}, 32'b1000);
    chk("t4_rst_wdata", mem_wdata, 32'd0);
    expect_write(0, 32'h11223344);
    send(8'h00, 1'b0); send(8'h01, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    @(posedge clk); #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h44, 1'b0);
`endif
    chk("t4_done", {done, cpu_run}, 32'b11);
    chk("t4_words", 32'(words_loaded), 32'd1);

    // Reload from DONE writes at address 0 again.
    pulse_start();
    chk("t6_run_low", {cpu_run, in_ready}, 32'b01);
    expect_write(0, 32'hDEADBEEF);
    send(8'h00, 1'b0); send(8'h01, 1'b0);
    send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b0);
    @(posedge clk); #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h22, 1'b0);
`endif
    chk("t6_done", {done, cpu_run}, 32'b11);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    expect_write(0, 32'h01020304);
    send(8'h00, 1'b0); send(8'h01, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    @(posedge clk); #1;
    send(8'h04, 1'b0);
    chk("t5_cks_ok", {done, error}, 32'b10);
    pulse_start();
    expect_write(0, 32'h01020304);
    send(8'h00, 1'b0); send(8'h01, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    @(posedge clk); #1;
    send(8'h05, 1'b0);
    chk("t5_cks_bad", {done, error, cpu_run}, 32'b010);
`endif

    repeat (3) @(posedge clk); #1;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
